// File: rtl/common_dffram_1wnr_valid.sv
// common_dffram_1wnr_valid
// ------------------------------------------------------------------------
// Flip-flop based register-file RAM with one write port, READ_PORTS
// independent read ports and a valid bit per entry. Reads of invalid or
// out-of-range entries return zero data with valid low. A flush clears
// every valid bit in one edge but leaves the data registers alone.
//
// Optional compile-time feature:
//    COMMON_DFFRAM_1WNR_WRITE_BYPASS_EN - when defined, a read that hits the
//    entry being written in the same cycle returns the post-write value,
//    and non-colliding reads during a flush cycle return valid 0. When
//    undefined, reads always show the pre-edge state.
//
// Ports:
//    clk     - clock
//    reset   - synchronous active-high reset; wins over flush and writes
//    flush   - clear all valid bits at the edge
//    addra   - write address (ADDR_W bits)
//    ena     - write port enable
//    wea     - write enable, per bit when PORTA_BIT_WRITE_ENABLE != 0
//    dina    - write data
//    addrb   - packed read addresses, port p at [ADDR_W*p +: ADDR_W]
//    enb     - per-port capture enable for the registered read stage
//    doutb   - packed read data, port p at [RAM_WIDTH*p +: RAM_WIDTH]
//    validb  - valid bit of the entry each port addresses
//    tvalid  - raw valid vector, straight from the valid flops
// ------------------------------------------------------------------------
module common_dffram_1wnr_valid #(
   parameter int RAM_WIDTH = 8,
   parameter int RAM_DEPTH = 16,
   parameter int READ_PORTS = 2,
   parameter logic [RAM_DEPTH*RAM_WIDTH-1:0] RAM_RESET_VALUE = '0,
   parameter int PORTA_BIT_WRITE_ENABLE = 0,
   parameter int READ_REGISTERED = 0,
   localparam int ADDR_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1,
   localparam int WE_W = (PORTA_BIT_WRITE_ENABLE != 0) ? RAM_WIDTH : 1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             flush,
   input  logic [ADDR_W-1:0]                addra,
   input  logic                             ena,
   input  logic [WE_W-1:0]                  wea,
   input  logic [RAM_WIDTH-1:0]             dina,
   input  logic [READ_PORTS*ADDR_W-1:0]     addrb,
   input  logic [READ_PORTS-1:0]            enb,
   output logic [READ_PORTS*RAM_WIDTH-1:0]  doutb,
   output logic [READ_PORTS-1:0]            validb,
   output logic [RAM_DEPTH-1:0]             tvalid
);

   // One extra bit so that a power-of-two depth still fits the limit.
   localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(RAM_DEPTH);

   logic [RAM_WIDTH-1:0]             mem_q [RAM_DEPTH];
   logic [RAM_DEPTH-1:0]             valid_q;
   logic [RAM_WIDTH-1:0]             wmask;
   logic                             wr_hit;
   logic                             wr_any;
   logic [RAM_DEPTH-1:0]             wr_sel;
   logic [READ_PORTS*RAM_WIDTH-1:0]  rd_data;
   logic [READ_PORTS-1:0]            rd_valid;
   logic [ADDR_W-1:0]                rd_addr;
   logic [RAM_WIDTH-1:0]             rd_word;
   logic                             rd_hit;

   // The write mask is either the per-bit enables directly, or the single
   // word enable replicated across the whole entry.
   if (PORTA_BIT_WRITE_ENABLE != 0) begin : g_bit_we
      assign wmask = wea;
   end else begin : g_word_we
      assign wmask = {RAM_WIDTH{wea[0]}};
   end

   // A write is only real when enabled and inside the array; any set enable
   // bit marks the entry valid, even for a partial write.
   assign wr_any = |wea;
   assign wr_hit = ena && ({1'b0, addra} < DEPTH_LIM);

   // One-hot write decode. Out-of-range addresses leave every bit clear, so
   // those writes cannot disturb any state.
   always_comb begin
      wr_sel = '0;
      for (int i = 0; i < RAM_DEPTH; i++) begin
         wr_sel[i] = wr_hit && (addra == ADDR_W'(i));
      end
   end

   // Storage and valid flops. Reset reloads the initial image and clears
   // validity. Flush clears every valid bit except the one being written in
   // the same cycle, so a write alongside a flush still lands as valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < RAM_DEPTH; i++) begin
            mem_q[i] <= RAM_RESET_VALUE[RAM_WIDTH*i +: RAM_WIDTH];
         end
         valid_q <= '0;
      end else begin
         for (int i = 0; i < RAM_DEPTH; i++) begin
            if (wr_sel[i]) begin
               mem_q[i] <= (mem_q[i] & ~wmask) | (dina & wmask);
            end
         end
         if (flush) begin
            valid_q <= wr_sel & {RAM_DEPTH{wr_any}};
         end else begin
            valid_q <= valid_q | (wr_sel & {RAM_DEPTH{wr_any}});
         end
      end
   end

   // Read ports: a one-hot compare against every entry, gated by that
   // entry's valid bit, then reduction-OR into the port word. Invalid and
   // out-of-range entries therefore read as zero with valid low. With the
   // bypass compiled in, a same-cycle write to the same address overrides
   // this result, with the stale-but-masked word supplying the bits the
   // write does not touch.
   always_comb begin
      rd_data  = '0;
      rd_valid = '0;
      rd_addr  = '0;
      rd_word  = '0;
      rd_hit   = 1'b0;
      for (int p = 0; p < READ_PORTS; p++) begin
         rd_addr = addrb[ADDR_W*p +: ADDR_W];
         rd_word = '0;
         rd_hit  = 1'b0;
         for (int i = 0; i < RAM_DEPTH; i++) begin
            if ((rd_addr == ADDR_W'(i)) && valid_q[i]) begin
               rd_word = rd_word | mem_q[i];
               rd_hit  = 1'b1;
            end
         end
`ifdef COMMON_DFFRAM_1WNR_WRITE_BYPASS_EN
         if (wr_hit && wr_any && (rd_addr == addra)) begin
            rd_word = (rd_word & ~wmask) | (dina & wmask);
            rd_hit  = 1'b1;
         end else if (flush) begin
            rd_word = '0;
            rd_hit  = 1'b0;
         end
`endif
         rd_data[RAM_WIDTH*p +: RAM_WIDTH] = rd_word;
         rd_valid[p] = rd_hit;
      end
   end

   // Output stage: either a per-port capture register that holds while its
   // enable is low, or a direct combinational path where enb has no role.
   if (READ_REGISTERED != 0) begin : g_read_reg
      logic [READ_PORTS*RAM_WIDTH-1:0] dout_q;
      logic [READ_PORTS-1:0]           vld_q;

      always_ff @(posedge clk) begin
         if (reset) begin
            dout_q <= '0;
            vld_q  <= '0;
         end else begin
            for (int p = 0; p < READ_PORTS; p++) begin
               if (enb[p]) begin
                  dout_q[RAM_WIDTH*p +: RAM_WIDTH] <= rd_data[RAM_WIDTH*p +: RAM_WIDTH];
                  vld_q[p] <= rd_valid[p];
               end
            end
         end
      end

      assign doutb  = dout_q;
      assign validb = vld_q;
   end else begin : g_read_comb
      logic unused_enb;
      assign unused_enb = ^enb;
      assign doutb  = rd_data;
      assign validb = rd_valid;
   end

   assign tvalid = valid_q;

endmodule

// File: tb/tb_common_dffram_1wnr_valid.sv
// tb_common_dffram_1wnr_valid
// ------------------------------------------------------------------------
// Directed self-checking bench. Two instances share clock and reset:
//    u_comb - depth 12, bit write enables, combinational reads, entry i
//             reset to value i
//    u_reg  - depth 16, word write enable, registered reads
// Expected values are written out by hand for each step; collision and
// flush-cycle reads depend on COMMON_DFFRAM_1WNR_WRITE_BYPASS_EN.
// ------------------------------------------------------------------------
module tb_common_dffram_1wnr_valid;

   logic        clk = 1'b0;
   logic        reset;

   logic        a_flush;
   logic [3:0]  a_addra;
   logic        a_ena;
   logic [7:0]  a_wea;
   logic [7:0]  a_dina;
   logic [7:0]  a_addrb;
   logic [1:0]  a_enb;
   logic [15:0] a_doutb;
   logic [1:0]  a_validb;
   logic [11:0] a_tvalid;

   logic        b_flush;
   logic [3:0]  b_addra;
   logic        b_ena;
   logic        b_wea;
   logic [7:0]  b_dina;
   logic [7:0]  b_addrb;
   logic [1:0]  b_enb;
   logic [15:0] b_doutb;
   logic [1:0]  b_validb;
   logic [15:0] b_tvalid;

   int checks = 0;
   int errors = 0;

   common_dffram_1wnr_valid #(
      .RAM_WIDTH(8),
      .RAM_DEPTH(12),
      .READ_PORTS(2),
      .RAM_RESET_VALUE(96'h0B0A_0908_0706_0504_0302_0100),
      .PORTA_BIT_WRITE_ENABLE(1),
      .READ_REGISTERED(0)
   ) u_comb (
      .clk(clk),
      .reset(reset),
      .flush(a_flush),
      .addra(a_addra),
      .ena(a_ena),
      .wea(a_wea),
      .dina(a_dina),
      .addrb(a_addrb),
      .enb(a_enb),
      .doutb(a_doutb),
      .validb(a_validb),
      .tvalid(a_tvalid)
   );

   common_dffram_1wnr_valid #(
      .RAM_WIDTH(8),
      .RAM_DEPTH(16),
      .READ_PORTS(2),
      .PORTA_BIT_WRITE_ENABLE(0),
      .READ_REGISTERED(1)
   ) u_reg (
      .clk(clk),
      .reset(reset),
      .flush(b_flush),
      .addra(b_addra),
      .ena(b_ena),
      .wea(b_wea),
      .dina(b_dina),
      .addrb(b_addrb),
      .enb(b_enb),
      .doutb(b_doutb),
      .validb(b_validb),
      .tvalid(b_tvalid)
   );

   // Free-running clock, 10 time units per period.
   always #5 clk = ~clk;

   // Compare one observed value against its hand-computed expectation.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Advance past the next rising edge; inputs change 1 unit after it.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Drive the write side of u_comb (no clock advance).
   task automatic applyStimulus(input logic ena, input logic [3:0] addr,
                                input logic [7:0] wea, input logic [7:0] din,
                                input logic flush);
      a_ena   = ena;
      a_addra = addr;
      a_wea   = wea;
      a_dina  = din;
      a_flush = flush;
   endtask

   // One complete write cycle on u_comb.
   task automatic writeA(input logic [3:0] addr, input logic [7:0] wea,
                         input logic [7:0] din);
      applyStimulus(1'b1, addr, wea, din, 1'b0);
      cycle();
      applyStimulus(1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
   endtask

   // Linear sequence of directed steps, checks taken on the falling edge.
   initial begin
      reset   = 1'b1;
      applyStimulus(1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
      a_addrb = 8'h00;
      a_enb   = 2'b00;
      b_flush = 1'b0;
      b_addra = 4'd0;
      b_ena   = 1'b0;
      b_wea   = 1'b0;
      b_dina  = 8'h00;
      b_addrb = 8'h00;
      b_enb   = 2'b00;

      repeat (2) @(posedge clk);
      #1;
      reset   = 1'b0;
      a_addrb = {4'd1, 4'd0};
      @(negedge clk);
      checkOutput("rst_a_tvalid", 32'(a_tvalid), 32'h0);
      checkOutput("rst_a_validb", 32'(a_validb), 32'h0);
      checkOutput("rst_a_doutb",  32'(a_doutb),  32'h0);
      checkOutput("rst_b_tvalid", 32'(b_tvalid), 32'h0);
      checkOutput("rst_b_validb", 32'(b_validb), 32'h0);
      checkOutput("rst_b_doutb",  32'(b_doutb),  32'h0);

      // Simple write then read back
      cycle();
      writeA(4'd3, 8'hFF, 8'hA5);
      a_addrb = {4'd0, 4'd3};
      @(negedge clk);
      checkOutput("wr3_data",  32'(a_doutb[7:0]), 32'hA5);
      checkOutput("wr3_valid", 32'(a_validb[0]),  32'h1);

      // Partial write over entry 7's reset value (7): upper nibble replaced
      cycle();
      writeA(4'd7, 8'hF0, 8'hA3);
      a_addrb = {4'd7, 4'd3};
      @(negedge clk);
      checkOutput("rstval7_doutb",  32'(a_doutb),  32'hA7A5);
      checkOutput("rstval7_validb", 32'(a_validb), 32'h3);

      // Two ports reading two different entries in one cycle
      cycle();
      writeA(4'd5, 8'hFF, 8'h11);
      writeA(4'd9, 8'hFF, 8'h22);
      a_addrb = {4'd9, 4'd5};
      @(negedge clk);
      checkOutput("mp_doutb",  32'(a_doutb),  32'h2211);
      checkOutput("mp_validb", 32'(a_validb), 32'h3);

      // Out-of-range read on port 1
      a_addrb = {4'd13, 4'd5};
      @(negedge clk);
      checkOutput("oor_rd_doutb",  32'(a_doutb),  32'h0011);
      checkOutput("oor_rd_validb", 32'(a_validb), 32'h1);

      // Writes to 13 and 12 (== depth) must be dropped
      cycle();
      writeA(4'd13, 8'hFF, 8'hEE);
      writeA(4'd12, 8'hFF, 8'hEE);
      a_addrb = {4'd13, 4'd12};
      @(negedge clk);
      checkOutput("oor_wr_tvalid", 32'(a_tvalid), 32'h2A8);
      checkOutput("oor_wr_doutb",  32'(a_doutb),  32'h0);
      checkOutput("oor_wr_validb", 32'(a_validb), 32'h0);

      // Bit-granular write: F0 with 0F under mask 3C gives CC; wea=0 to 11
      // leaves it invalid
      cycle();
      writeA(4'd4, 8'hFF, 8'hF0);
      writeA(4'd4, 8'h3C, 8'h0F);
      writeA(4'd11, 8'h00, 8'h55);
      a_addrb = {4'd11, 4'd4};
      @(negedge clk);
      checkOutput("bw_doutb",  32'(a_doutb),  32'h00CC);
      checkOutput("bw_validb", 32'(a_validb), 32'h1);
      checkOutput("bw_tvalid", 32'(a_tvalid), 32'h2B8);

      // Make entries 0..3 valid
      cycle();
      writeA(4'd0, 8'hFF, 8'h10);
      writeA(4'd1, 8'hFF, 8'h20);
      writeA(4'd2, 8'hFF, 8'h30);
      @(negedge clk);
      checkOutput("pre_flush_tvalid", 32'(a_tvalid), 32'h2BF);

      // Flush together with a write to entry 2
      cycle();
      applyStimulus(1'b1, 4'd2, 8'hFF, 8'h7E, 1'b1);
      a_addrb = {4'd1, 4'd2};
      @(negedge clk);
`ifdef COMMON_DFFRAM_1WNR_WRITE_BYPASS_EN
      checkOutput("flush_cyc_doutb",  32'(a_doutb),  32'h007E);
      checkOutput("flush_cyc_validb", 32'(a_validb), 32'h1);
`else
      checkOutput("flush_cyc_doutb",  32'(a_doutb),  32'h2030);
      checkOutput("flush_cyc_validb", 32'(a_validb), 32'h3);
`endif
      cycle();
      applyStimulus(1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
      @(negedge clk);
      checkOutput("flush_tvalid", 32'(a_tvalid), 32'h004);
      checkOutput("flush_doutb",  32'(a_doutb),  32'h007E);
      checkOutput("flush_validb", 32'(a_validb), 32'h1);

      // Same-cycle write/read collision on never-written entry 6
      cycle();
      applyStimulus(1'b1, 4'd6, 8'hFF, 8'h5A, 1'b0);
      a_addrb = {4'd2, 4'd6};
      @(negedge clk);
`ifdef COMMON_DFFRAM_1WNR_WRITE_BYPASS_EN
      checkOutput("coll_doutb",  32'(a_doutb),  32'h7E5A);
      checkOutput("coll_validb", 32'(a_validb), 32'h3);
`else
      checkOutput("coll_doutb",  32'(a_doutb),  32'h7E00);
      checkOutput("coll_validb", 32'(a_validb), 32'h2);
`endif
      cycle();
      applyStimulus(1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
      @(negedge clk);
      checkOutput("coll_after_doutb",  32'(a_doutb),  32'h7E5A);
      checkOutput("coll_after_validb", 32'(a_validb), 32'h3);

      // Flush kept entry 1's data: partial write 05 under 0F gives 25
      cycle();
      writeA(4'd1, 8'h0F, 8'h05);
      a_addrb = {4'd1, 4'd6};
      @(negedge clk);
      checkOutput("flush_keep_doutb",  32'(a_doutb),  32'h255A);
      checkOutput("flush_keep_validb", 32'(a_validb), 32'h3);

      // Registered path: write entry 5, then capture with enb[0]
      cycle();
      b_ena = 1'b1; b_addra = 4'd5; b_wea = 1'b1; b_dina = 8'h33;
      cycle();
      b_ena = 1'b0;
      b_addrb = {4'd0, 4'd5};
      b_enb = 2'b01;
      @(negedge clk);
      checkOutput("reg_lat_doutb",  32'(b_doutb),  32'h0);
      checkOutput("reg_lat_validb", 32'(b_validb), 32'h0);
      cycle();
      @(negedge clk);
      checkOutput("reg_cap_doutb",  32'(b_doutb),  32'h0033);
      checkOutput("reg_cap_validb", 32'(b_validb), 32'h1);

      // enb low: address and data change, output holds
      b_enb = 2'b00;
      b_addrb = {4'd0, 4'd0};
      b_ena = 1'b1; b_addra = 4'd5; b_wea = 1'b1; b_dina = 8'h44;
      cycle();
      b_ena = 1'b0;
      cycle();
      @(negedge clk);
      checkOutput("reg_hold_doutb",  32'(b_doutb),  32'h0033);
      checkOutput("reg_hold_validb", 32'(b_validb), 32'h1);
      checkOutput("reg_hold_tvalid", 32'(b_tvalid), 32'h0020);
      b_enb = 2'b01;
      b_addrb = {4'd0, 4'd5};
      cycle();
      @(negedge clk);
      checkOutput("reg_recap_doutb", 32'(b_doutb), 32'h0044);

      // Registered capture during a same-cycle write to entry 7
      b_ena = 1'b1; b_addra = 4'd7; b_wea = 1'b1; b_dina = 8'h77;
      b_addrb = {4'd7, 4'd5};
      b_enb = 2'b11;
      cycle();
      b_ena = 1'b0;
      @(negedge clk);
`ifdef COMMON_DFFRAM_1WNR_WRITE_BYPASS_EN
      checkOutput("reg_coll_doutb",  32'(b_doutb),  32'h7744);
      checkOutput("reg_coll_validb", 32'(b_validb), 32'h3);
`else
      checkOutput("reg_coll_doutb",  32'(b_doutb),  32'h0044);
      checkOutput("reg_coll_validb", 32'(b_validb), 32'h1);
`endif
      cycle();
      @(negedge clk);
      checkOutput("reg_coll_after_doutb",  32'(b_doutb),  32'h7744);
      checkOutput("reg_coll_after_validb", 32'(b_validb), 32'h3);

      // Reset mid-operation with concurrent enb, write and flush
      reset = 1'b1;
      b_ena = 1'b1; b_addra = 4'd2; b_wea = 1'b1; b_dina = 8'h99;
      b_flush = 1'b1;
      applyStimulus(1'b1, 4'd0, 8'hFF, 8'hFF, 1'b0);
      cycle();
      reset = 1'b0;
      b_ena = 1'b0;
      b_flush = 1'b0;
      b_enb = 2'b00;
      applyStimulus(1'b0, 4'd0, 8'h00, 8'h00, 1'b0);
      @(negedge clk);
      checkOutput("rst2_b_doutb",  32'(b_doutb),  32'h0);
      checkOutput("rst2_b_validb", 32'(b_validb), 32'h0);
      checkOutput("rst2_b_tvalid", 32'(b_tvalid), 32'h0);
      checkOutput("rst2_a_tvalid", 32'(a_tvalid), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/common_dffram_1wnr_valid.md
# common_dffram_1wnr_valid

Parametrised DFF-based register-file RAM with one write port and `READ_PORTS` independent read ports. It keeps a valid bit per entry and supports a synchronous bulk invalidate (flush), optional bit-granular write enable, and an optional registered read stage. It is the multi-read-port successor of the simple dual-port DFF RAM, intended for small tag/metadata arrays and register files in the pipeline.

## Interface
Parameters:
- `RAM_WIDTH`, 8, data bits per entry (≥1)
- `RAM_DEPTH`, 16, number of entries (≥1, need not be a power of two)
- `READ_PORTS`, 2, number of read ports (≥1)
- `RAM_RESET_VALUE`, all zeros, `RAM_DEPTH*RAM_WIDTH` bits; entry i's reset value is at `[RAM_WIDTH*i +: RAM_WIDTH]`
- `PORTA_BIT_WRITE_ENABLE`, 0, when 1 `wea` is `RAM_WIDTH` bits wide; when 0 it is 1 bit
- `READ_REGISTERED`, 0, when 0 reads are combinational; when 1 read data is registered (1-cycle latency)
- Local `ADDR_W`: `max(1, $clog2(RAM_DEPTH))`
- Local `WE_W`: `PORTA_BIT_WRITE_ENABLE ? RAM_WIDTH : 1`

Ports:
- `clk`, in, 1, clock. One clock domain; reset is synchronous and active-high.
- `reset`, in, 1, synchronous active-high reset
- `flush`, in, 1, clears every valid bit at the clock edge
- `addra`, in, `ADDR_W`, binary write address
- `ena`, in, 1, write port enable
- `wea`, in, `WE_W`, write enable (per bit when `PORTA_BIT_WRITE_ENABLE`)
- `dina`, in, `RAM_WIDTH`, write data
- `addrb`, in, `READ_PORTS*ADDR_W`, binary read addresses; port p is at `[ADDR_W*p +: ADDR_W]`
- `enb`, in, `READ_PORTS`, per-port read enable. Used only when `READ_REGISTERED=1`; ignored otherwise.
- `doutb`, out, `READ_PORTS*RAM_WIDTH`, read data; port p is at `[RAM_WIDTH*p +: RAM_WIDTH]`
- `validb`, out, `READ_PORTS`, valid bit of the addressed entry per port
- `tvalid`, out, `RAM_DEPTH`, raw valid bit vector (always combinational from state)

## Operation
- **Storage:** `RAM_DEPTH` data registers plus `RAM_DEPTH` valid flops.
- **Reset:**
  - Data entries load `RAM_RESET_VALUE`.
  - All valid bits go to 0.
  - Read registers (when `READ_REGISTERED=1`) go to `doutb=0`, `validb=0`.
  - Reset overrides `flush` and writes.
- **Write:** occurs when `ena` is high and `addra < RAM_DEPTH`.
  - Bit-write mode: data bit j updates iff `wea[j]`.
  - Word mode: the entry updates iff `wea`.
  - The entry's valid bit is set iff any `wea` bit is 1.
  - `addra ≥ RAM_DEPTH`: the write is dropped and no state changes.
- **Flush:** all valid bits clear at the edge; data contents are unchanged.
  - Flush together with a valid write in the same cycle: the written entry ends valid (write wins); all others are cleared.
- **Read (per port p, independent):**
  - Addressed entry valid: `data = entry`, `valid = 1`.
  - Addressed entry invalid: `data = 0`, `valid = 0` (invalid data is masked to zero).
  - `addrb_p ≥ RAM_DEPTH`: data 0, valid 0.
- **Write/read collision (same address, same cycle):** returns pre-write state unless bypass is compiled in (see Configuration).
- **Output mux:** one-hot select with reduction-OR.

## Timing
- `READ_REGISTERED=0`: `doutb`/`validb` are combinational from `addrb` and current state. A write becomes visible the cycle after its edge.
- `READ_REGISTERED=1`:
  - At each edge where `enb[p]=1`, port p's registers capture the read result evaluated from the pre-edge state (or the bypassed result, see Configuration).
  - With `enb[p]=0`, port p holds its outputs.
  - Latency is 1 cycle from address to output.
- **Flush visibility:** the cycle after the flush edge, every read returns valid 0 except entries written in the flush cycle.
- **Reset mid-operation:** the cycle after the reset edge, all outputs equal their reset values, regardless of a concurrent `ena`/`flush`/`enb`.
- **Throughput:** no back-pressure. One write and `READ_PORTS` reads every cycle.

## Configuration
- Macro: `COMMON_DFFRAM_1WNR_WRITE_BYPASS_EN`.
- **Defined:** a read whose address equals a valid write (`ena`, `addra < RAM_DEPTH`, any `wea` bit set) in the same cycle returns:
  - data: the post-write entry (`dina` on enabled bits, old data on others; old data is taken as 0 if the entry was invalid);
  - valid: 1.
  
  This applies to the combinational path and to the capture of the registered path. A read in a flush cycle (non-colliding) returns valid 0.
- **Undefined:** no forwarding. Reads always reflect the pre-edge state, including during flush cycles. No bypass comparators are instantiated.

## Test plan
- **Reset:** `RAM_RESET_VALUE` = entry i holds i; assert `reset` 1 cycle -> `tvalid=0`; all `validb=0`, `doutb=0`. Write `0xA5` to addr 3, then read addr 3 -> `0xA5`, valid 1.
- **Multi-port:** write 5→`0x11` and 9→`0x22`; then port0 reads 5 and port1 reads 9 in the same cycle -> `0x11`/`0x22`, both valid. Any address ≥ `RAM_DEPTH` (e.g. 16 with `RAM_DEPTH=16` requires `RAM_DEPTH=12`, addr 13) -> data 0, valid 0, and a write to addr 13 changes no state.
- **Flush:** entries 0–3 valid; assert `flush` with a write to addr 2 = `0x7E` -> next cycle `tvalid=4'b0100`, read 2 = `0x7E`, read 1 = 0/valid 0.
- **Bit-write:** `PORTA_BIT_WRITE_ENABLE=1`; entry 4 = `0xF0`; write `dina=0x0F`, `wea=0x3C` -> entry reads `0xCC`.
- **Collision:** write addr 6 = `0x5A` while port0 reads addr 6 -> with macro: same-cycle read `0x5A`/valid 1; without macro: old value (0/valid 0 if never written). Next cycle both builds give `0x5A`.
- **Registered path:** `READ_REGISTERED=1`; `enb=1` at addr 5 -> data appears one cycle later. Drop `enb`, then change addr/data -> output holds. Assert `reset` while `enb=1` -> outputs 0 next cycle.
